// File: rtl/seq_pkg.sv
// Shared types for the tune sequencer: song step layout, sequencer states and the REST code.
package seq_pkg;

  localparam int SEQ_PITCH_W = 6;
  localparam int SEQ_LEN_W   = 4;

  localparam logic [SEQ_PITCH_W-1:0] REST = '1;

  typedef struct packed {
    logic [SEQ_PITCH_W-1:0] pitch;
    logic [SEQ_LEN_W-1:0]   len;
  } seq_step_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY
  } seq_state_t;

endpackage

// File: rtl/step_ram.sv
// Song memory: simple dual-port, synchronous read-first RAM with one write and one read port.
module step_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 10
) (
  input  logic                     clk,
  input  logic                     i_wrEn,
  input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
  input  logic [DW-1:0]            i_wrData,
  input  logic                     i_rdEn,
  input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
  output logic [DW-1:0]            o_rdData
);

  logic [DW-1:0] r_mem [DEPTH];

  // No reset so the array maps onto block RAM; a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      o_rdData <= r_mem[i_rdAddr];
    end
  end

endmodule

// File: rtl/tune_sequencer.sv
// Multi-voice step sequencer: fetches (pitch, length) steps from song memory and drives
// per-voice note indices and envelope-restart strobes at a tempo counted in sample ticks.
module tune_sequencer
  import seq_pkg::*;
#(
  parameter int N_VOICES = 2,
  parameter int DEPTH    = 64,
  parameter int PITCH_W  = SEQ_PITCH_W,
  parameter int LEN_W    = SEQ_LEN_W,
  parameter int TICK_W   = 16,
  parameter int N_NOTES  = 41
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_tick,
  input  logic                               wr_en,
  input  logic [$clog2(DEPTH)-1:0]           wr_addr,
  input  logic [PITCH_W-1:0]                 wr_pitch,
  input  logic [LEN_W-1:0]                   wr_len,
  input  logic [N_VOICES-1:0][PITCH_W-1:0]   voice_offset,
  input  logic [TICK_W-1:0]                  ticks_per_unit,
  input  logic [$clog2(DEPTH):0]             song_len,
  input  logic                               loop,
  input  logic                               start,
  input  logic                               stop,
  output logic [N_VOICES-1:0][PITCH_W-1:0]   pitch,
  output logic [N_VOICES-1:0]                note_valid,
  output logic [N_VOICES-1:0]                env_reset,
  output logic                               playing,
  output logic [$clog2(DEPTH)-1:0]           step_idx,
  output logic                               done
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = PITCH_W + LEN_W;
  localparam logic [PITCH_W-1:0] PITCH_REST = {PITCH_W{1'b1}};
  localparam logic [PITCH_W:0]   NOTE_LIM   = (PITCH_W+1)'(N_NOTES);

  seq_state_t r_state, w_stateNext;

  logic [AW-1:0]                     r_idx, w_idxNext;
  logic [TICK_W-1:0]                 r_tickCnt, w_tickNext;
  logic [LEN_W-1:0]                  r_unitCnt, w_unitNext;
  logic [LEN_W-1:0]                  r_len, w_lenNext;
  logic [N_VOICES-1:0][PITCH_W-1:0]  r_pitch, w_pitchNext;
  logic [N_VOICES-1:0]               r_noteValid, w_validNext;
  logic [N_VOICES-1:0]               r_envReset, w_envNext;
  logic                              r_done, w_doneNext;

  logic [DW-1:0]                     w_ramRdData;
  logic                              w_ramRdEn;
  logic [PITCH_W-1:0]                w_rdPitch;
  logic [LEN_W-1:0]                  w_rdLen;
  logic [N_VOICES-1:0][PITCH_W:0]    w_sum;
  logic [N_VOICES-1:0]               w_voiceOk;
  logic [TICK_W-1:0]                 w_tickMax;
  logic [LEN_W-1:0]                  w_unitMax;
  logic                              w_lastStep;

  step_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_stepRam (
    .clk      (clk),
    .i_wrEn   (wr_en),
    .i_wrAddr (wr_addr),
    .i_wrData ({wr_pitch, wr_len}),
    .i_rdEn   (w_ramRdEn),
    .i_rdAddr (r_idx),
    .o_rdData (w_ramRdData)
  );

  assign w_ramRdEn = (r_state == FETCH);
  assign w_rdPitch = w_ramRdData[DW-1 -: PITCH_W];
  assign w_rdLen   = w_ramRdData[LEN_W-1:0];

  // A zero tempo or zero length behaves as one, so the compare limits bottom out at 0.
  assign w_tickMax  = (ticks_per_unit == '0) ? '0 : ticks_per_unit - TICK_W'(1);
  assign w_unitMax  = (r_len == '0) ? '0 : r_len - LEN_W'(1);
  assign w_lastStep = (({1'b0, r_idx} + (AW+1)'(1)) >= song_len);

  // Offset sums are one bit wider so a wrap past the note table shows up as out of range.
  always_comb begin
    w_sum     = '0;
    w_voiceOk = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      w_sum[v]     = {1'b0, w_rdPitch} + {1'b0, voice_offset[v]};
      w_voiceOk[v] = (w_rdPitch != PITCH_REST) && (w_sum[v] < NOTE_LIM);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_tickNext  = r_tickCnt;
    w_unitNext  = r_unitCnt;
    w_lenNext   = r_len;
    w_pitchNext = r_pitch;
    w_validNext = r_noteValid;
    w_envNext   = '0;
    w_doneNext  = 1'b0;

    if (stop) begin
      w_stateNext = IDLE;
      w_validNext = '0;
      w_tickNext  = '0;
      w_unitNext  = '0;
    end else if (start) begin
      if ((r_state == IDLE) && (song_len == '0)) begin
        w_doneNext = 1'b1;
      end else begin
        w_stateNext = FETCH;
        w_idxNext   = '0;
        w_tickNext  = '0;
        w_unitNext  = '0;
      end
    end else begin
      case (r_state)
        IDLE:  w_stateNext = IDLE;
        FETCH: w_stateNext = LOAD;
        LOAD: begin
          w_stateNext = PLAY;
          w_lenNext   = w_rdLen;
          w_tickNext  = '0;
          w_unitNext  = '0;
          for (int v = 0; v < N_VOICES; v++) begin
            w_validNext[v] = w_voiceOk[v];
            w_envNext[v]   = w_voiceOk[v];
            if (w_voiceOk[v]) begin
              w_pitchNext[v] = w_sum[v][PITCH_W-1:0];
            end
          end
        end
        PLAY: begin
          // Greater-or-equal compares keep a live tempo decrease from overrunning the counter.
          if (sample_tick) begin
            if (r_tickCnt >= w_tickMax) begin
              w_tickNext = '0;
              if (r_unitCnt >= w_unitMax) begin
                w_unitNext = '0;
                if (!w_lastStep) begin
                  w_idxNext   = r_idx + AW'(1);
                  w_stateNext = FETCH;
                end else if (loop) begin
                  w_idxNext   = '0;
                  w_stateNext = FETCH;
                end else begin
                  w_stateNext = IDLE;
                  w_validNext = '0;
                  w_doneNext  = 1'b1;
                end
              end else begin
                w_unitNext = r_unitCnt + LEN_W'(1);
              end
            end else begin
              w_tickNext = r_tickCnt + TICK_W'(1);
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tickCnt   <= '0;
      r_unitCnt   <= '0;
      r_len       <= '0;
      r_pitch     <= '0;
      r_noteValid <= '0;
      r_envReset  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_idx       <= w_idxNext;
      r_tickCnt   <= w_tickNext;
      r_unitCnt   <= w_unitNext;
      r_len       <= w_lenNext;
      r_pitch     <= w_pitchNext;
      r_noteValid <= w_validNext;
      r_envReset  <= w_envNext;
      r_done      <= w_doneNext;
    end
  end

  assign pitch      = r_pitch;
  assign note_valid = r_noteValid;
  assign env_reset  = r_envReset;
  assign done       = r_done;
  assign step_idx   = r_idx;
  assign playing    = (r_state != IDLE);

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: a song-level playback model checked every cycle, plus
// hand-computed expectations at the key moments of each directed scenario.
module tb_tune_sequencer;
  import seq_pkg::*;

  localparam int NV    = 2;
  localparam int DEPTH = 64;
  localparam int PW    = 6;
  localparam int LW    = 4;
  localparam int TW    = 16;
  localparam int NN    = 41;
  localparam int AW    = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   sample_tick = 1'b0;
  logic                   wr_en = 1'b0;
  logic [AW-1:0]          wr_addr = '0;
  logic [PW-1:0]          wr_pitch = '0;
  logic [LW-1:0]          wr_len = '0;
  logic [NV-1:0][PW-1:0]  voice_offset = '0;
  logic [TW-1:0]          ticks_per_unit = 16'd4;
  logic [AW:0]            song_len = 7'd3;
  logic                   loop = 1'b0;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic [NV-1:0][PW-1:0]  pitch;
  logic [NV-1:0]          note_valid;
  logic [NV-1:0]          env_reset;
  logic                   playing;
  logic [AW-1:0]          step_idx;
  logic                   done;

  tune_sequencer #(
    .N_VOICES (NV),
    .DEPTH    (DEPTH),
    .PITCH_W  (PW),
    .LEN_W    (LW),
    .TICK_W   (TW),
    .N_NOTES  (NN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick    (sample_tick),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_pitch       (wr_pitch),
    .wr_len         (wr_len),
    .voice_offset   (voice_offset),
    .ticks_per_unit (ticks_per_unit),
    .song_len       (song_len),
    .loop           (loop),
    .start          (start),
    .stop           (stop),
    .pitch          (pitch),
    .note_valid     (note_valid),
    .env_reset      (env_reset),
    .playing        (playing),
    .step_idx       (step_idx),
    .done           (done)
  );

  always #5 clk = ~clk;

  int checkCnt = 0;
  int passCnt  = 0;
  bit chkEn    = 1'b0;
  int relCyc   = 0;
  int tickPh   = 0;
  bit tickEn   = 1'b0;

  // Playback model: a step becomes audible three edges after it is requested and lasts
  // len*tempo sample ticks; the memory word is captured one edge after the request.
  seq_step_t             mMem [DEPTH];
  seq_step_t             mFetched = '0;
  bit                    mActive = 1'b0;
  int                    mIdx = 0;
  int                    mLatency = 0;
  int                    mTicksLeft = 0;
  int                    mP = 0;
  logic [NV-1:0][PW-1:0] mPitch = '0;
  logic [NV-1:0]         mValid = '0;
  logic [NV-1:0]         mEnv = '0;
  bit                    mDone = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mActive = 1'b0; mIdx = 0; mLatency = 0; mTicksLeft = 0;
        mPitch = '0; mValid = '0; mEnv = '0; mDone = 1'b0;
      end else begin
        mEnv  = '0;
        mDone = 1'b0;
        if (stop) begin
          mActive = 1'b0; mLatency = 0; mValid = '0;
        end else if (start) begin
          if (!mActive && song_len == 0) mDone = 1'b1;
          else begin
            mActive = 1'b1; mIdx = 0; mLatency = 2;
          end
        end else if (mActive) begin
          if (mLatency == 2) begin
            mFetched = mMem[mIdx];
            mLatency = 1;
          end else if (mLatency == 1) begin
            mLatency   = 0;
            mTicksLeft = ((mFetched.len == 0) ? 1 : int'(mFetched.len)) *
                         ((ticks_per_unit == 0) ? 1 : int'(ticks_per_unit));
            for (int v = 0; v < NV; v++) begin
              mP = int'(mFetched.pitch) + int'(voice_offset[v]);
              if (mFetched.pitch != REST && mP < NN) begin
                mPitch[v] = PW'(mP);
                mValid[v] = 1'b1;
                mEnv[v]   = 1'b1;
              end else begin
                mValid[v] = 1'b0;
              end
            end
          end else if (sample_tick) begin
            mTicksLeft = mTicksLeft - 1;
            if (mTicksLeft == 0) begin
              if (mIdx + 1 >= int'(song_len)) begin
                if (loop) begin
                  mIdx = 0; mLatency = 2;
                end else begin
                  mActive = 1'b0; mDone = 1'b1; mValid = '0;
                end
              end else begin
                mIdx = mIdx + 1; mLatency = 2;
              end
            end
          end
        end
        if (wr_en) mMem[wr_addr] = '{pitch: wr_pitch, len: wr_len};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // Whole-output comparison against the model on every cycle once reset has been applied.
  initial begin
    forever begin
      @(negedge clk);
      if (chkEn) begin
        checkOutput("cycle outputs",
                    {8'h00, pitch, note_valid, env_reset, playing, step_idx, done},
                    {8'h00, mPitch, mValid, mEnv, mActive, AW'(mIdx), mDone});
      end
    end
  end

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    relCyc++;
    if (tickEn) begin
      tickPh++;
      sample_tick = (tickPh % 4 == 0);
    end else begin
      sample_tick = 1'b0;
    end
  endtask

  task automatic runTo(input int n);
    while (relCyc < n) applyStimulus();
  endtask

  task automatic writeStep(input int addr, input logic [PW-1:0] p, input logic [LW-1:0] l);
    applyStimulus();
    wr_en = 1'b1; wr_addr = AW'(addr); wr_pitch = p; wr_len = l;
    applyStimulus();
    wr_en = 1'b0;
  endtask

  // Start is high in relative cycle 0; ticks then arrive every 4th cycle from cycle 4.
  task automatic startSong();
    applyStimulus();
    start = 1'b1; sample_tick = 1'b0;
    tickEn = 1'b1; tickPh = 0; relCyc = 0;
    applyStimulus();
    start = 1'b0;
  endtask

  task automatic stopSong();
    stop = 1'b1; tickEn = 1'b0;
    applyStimulus();
    stop = 1'b0;
  endtask

  initial begin
    voice_offset[0] = 6'd0;
    voice_offset[1] = 6'd4;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chkEn = 1'b1;
    checkOutput("reset outputs", {8'h00, pitch, note_valid, env_reset, playing, step_idx, done}, 32'h0);

    // Three-step song without looping.
    writeStep(0, 6'd12, 4'd1);
    writeStep(1, 6'd16, 4'd2);
    writeStep(2, REST, 4'd1);
    startSong();
    runTo(3);
    checkOutput("s0 v0 pitch", 32'(pitch[0]), 32'd12);
    checkOutput("s0 v1 pitch", 32'(pitch[1]), 32'd16);
    checkOutput("s0 env_reset", 32'(env_reset), 32'h3);
    checkOutput("s0 note_valid", 32'(note_valid), 32'h3);
    runTo(4);
    checkOutput("s0 env one cycle", 32'(env_reset), 32'h0);
    runTo(18);
    checkOutput("s1 not yet", 32'(env_reset), 32'h0);
    runTo(19);
    checkOutput("s1 v0 pitch", 32'(pitch[0]), 32'd16);
    checkOutput("s1 v1 pitch", 32'(pitch[1]), 32'd20);
    checkOutput("s1 env_reset", 32'(env_reset), 32'h3);
    checkOutput("s1 step_idx", 32'(step_idx), 32'd1);
    runTo(51);
    checkOutput("rest note_valid", 32'(note_valid), 32'h0);
    checkOutput("rest env_reset", 32'(env_reset), 32'h0);
    checkOutput("rest pitch held", 32'(pitch[1]), 32'd20);
    runTo(64);
    checkOutput("done early", 32'(done), 32'h0);
    runTo(65);
    checkOutput("done pulse", 32'(done), 32'h1);
    checkOutput("idle after done", 32'(playing), 32'h0);
    runTo(66);
    checkOutput("done one cycle", 32'(done), 32'h0);
    tickEn = 1'b0;

    // Same song looping back to step 0.
    loop = 1'b1;
    startSong();
    runTo(65);
    checkOutput("loop no done", 32'(done), 32'h0);
    runTo(67);
    checkOutput("loop env_reset", 32'(env_reset), 32'h3);
    checkOutput("loop step_idx", 32'(step_idx), 32'd0);
    checkOutput("loop v0 pitch", 32'(pitch[0]), 32'd12);
    runTo(69);
    stopSong();
    checkOutput("loop stop playing", 32'(playing), 32'h0);
    loop = 1'b0;

    // Stop in the middle of step 1, then start and stop together.
    startSong();
    runTo(25);
    stopSong();
    checkOutput("stop playing", 32'(playing), 32'h0);
    checkOutput("stop note_valid", 32'(note_valid), 32'h0);
    checkOutput("stop no done", 32'(done), 32'h0);
    runTo(40);
    start = 1'b1; stop = 1'b1;
    applyStimulus();
    start = 1'b0; stop = 1'b0;
    checkOutput("start+stop idle", 32'(playing), 32'h0);

    // Voice 1 pushed past the top of the note table.
    writeStep(0, 6'd38, 4'd1);
    song_len = 7'd1;
    startSong();
    runTo(3);
    checkOutput("range v0 pitch", 32'(pitch[0]), 32'd38);
    checkOutput("range note_valid", 32'(note_valid), 32'h1);
    checkOutput("range env_reset", 32'(env_reset), 32'h1);
    checkOutput("range v1 held", 32'(pitch[1]), 32'd20);
    runTo(17);
    checkOutput("range done", 32'(done), 32'h1);
    tickEn = 1'b0;

    // Asynchronous reset in the middle of a step.
    writeStep(0, 6'd12, 4'd1);
    song_len = 7'd3;
    startSong();
    runTo(10);
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs", {8'h00, pitch, note_valid, env_reset, playing, step_idx, done}, 32'h0);
    tickEn = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    startSong();
    runTo(3);
    checkOutput("post-reset v0 pitch", 32'(pitch[0]), 32'd12);
    checkOutput("post-reset step_idx", 32'(step_idx), 32'd0);
    stopSong();

    // Rewrite step 1 while step 0 plays, with a zero tempo (one tick per unit).
    ticks_per_unit = 16'd0;
    startSong();
    runTo(3);
    wr_en = 1'b1; wr_addr = 6'd1; wr_pitch = 6'd20; wr_len = 4'd1;
    applyStimulus();
    wr_en = 1'b0;
    runTo(7);
    checkOutput("rewrite v0 pitch", 32'(pitch[0]), 32'd20);
    checkOutput("rewrite v1 pitch", 32'(pitch[1]), 32'd24);
    checkOutput("rewrite env_reset", 32'(env_reset), 32'h3);
    runTo(13);
    checkOutput("tpu0 done", 32'(done), 32'h1);
    tickEn = 1'b0;
    ticks_per_unit = 16'd4;

    // Write to the address being fetched: the fetch sees the old word.
    song_len = 7'd1;
    startSong();
    wr_en = 1'b1; wr_addr = 6'd0; wr_pitch = 6'd30; wr_len = 4'd1;
    applyStimulus();
    wr_en = 1'b0;
    runTo(3);
    checkOutput("collide old data", 32'(pitch[0]), 32'd12);
    stopSong();
    startSong();
    runTo(3);
    checkOutput("collide new data", 32'(pitch[0]), 32'd30);
    checkOutput("collide v1 pitch", 32'(pitch[1]), 32'd34);
    stopSong();

    // Empty song: start only pulses done.
    song_len = 7'd0;
    applyStimulus();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("empty done", 32'(done), 32'h1);
    checkOutput("empty idle", 32'(playing), 32'h0);
    applyStimulus();
    checkOutput("empty done one cycle", 32'(done), 32'h0);
    applyStimulus();

    chkEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
